serial_compare_scheduler: RTL and testbench



---
 rtl/serial_compare_scheduler_if.sv | 28 ++
 rtl/serial_compare_scheduler.sv | 112 +++++++++++
 tb/tb_serial_compare_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_scheduler_if.sv
// serial_compare_scheduler_if: request and response channels of the shared serial comparator
interface serial_compare_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_less;
    logic                   rsp_eq;
    logic                   rsp_greater;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_greater, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_greater, busy
    );
endinterface

// File: rtl/serial_compare_scheduler.sv
// serial_compare_scheduler: round-robin shares one MSB-first serial magnitude comparator.
// Build macro SERIAL_CMP_EARLY_EXIT_EN ends the shift phase at the first differing bit.
module serial_compare_scheduler #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input logic clk,
    input logic rst,
    serial_compare_scheduler_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d, id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eq_q, eq_d, less_q, less_d;
    logic             grant_found;
    int               grant_idx;
    logic             a_bit, b_bit, eq_n, early_exit, done;

    assign a_bit = a_q[cnt_q];
    assign b_bit = b_q[cnt_q];
    assign eq_n  = eq_q & (a_bit == b_bit);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign early_exit = ~eq_n;
`else
    assign early_exit = 1'b0;
`endif

    // Round-robin search for the first valid requester after the last one served
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_found && bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = (int'(ptr_q) + k) % N_REQ;
            end
        end
    end

    // Next-state logic: latch on grant, fold one bit per SHIFT cycle, hold result until taken
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        less_d  = less_q;
        case (state_q)
            IDLE: if (grant_found) begin
                a_d     = bus.req_a[grant_idx*WIDTH +: WIDTH];
                b_d     = bus.req_b[grant_idx*WIDTH +: WIDTH];
                id_d    = ID_W'(grant_idx);
                ptr_d   = ID_W'(grant_idx);
                eq_d    = 1'b1;
                less_d  = 1'b0;
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                eq_d    = eq_n;
                less_d  = less_q | (eq_q & ~a_bit & b_bit);
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == '0 || early_exit) ? DONE : SHIFT;
            end
            DONE: state_d = bus.rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            less_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            less_q  <= less_d;
        end
    end

    assign done = (state_q == DONE);

    // req_ready is forced low while reset is held so it matches its reset value
    assign bus.req_ready   = (state_q == IDLE && !rst && grant_found) ? N_REQ'(1) << grant_idx : '0;
    assign bus.rsp_valid   = done;
    assign bus.rsp_id      = done ? id_q : '0;
    assign bus.rsp_eq      = done & eq_q;
    assign bus.rsp_less    = done & less_q;
    assign bus.rsp_greater = done & ~eq_q & ~less_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_serial_compare_scheduler.sv
// tb_serial_compare_scheduler: directed and random checks against a behavioural comparator model
module tb_serial_compare_scheduler;
    localparam int W = 8;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    serial_compare_scheduler_if #(.WIDTH(W), .N_REQ(N), .ID_W(1)) bus ();

    serial_compare_scheduler #(.WIDTH(W), .N_REQ(N), .ID_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Result appears lat cycles after the handshake cycle
    function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int k = 1; k <= W; k++)
            if (a[W-k] != b[W-k]) return k + 1;
`endif
        return W + 1;
    endfunction

    function automatic logic [2:0] flags_of(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a < b, a == b, a > b};
    endfunction

    // Behavioural model: idle/busy, cycles left before the result shows, last served requester
    logic         m_busy;
    int           m_wait;
    int           m_last;
    int           m_id;
    logic [2:0]   m_flags;
    int           gi;
    logic [N-1:0] e_ready;
    logic         e_valid;
    logic [W-1:0] ma, mb;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_wait = 0;
            m_last = N - 1;
            chk("rst_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_less,
                                bus.rsp_eq, bus.rsp_greater, bus.busy}, 0);
        end else begin
            gi = -1;
            if (!m_busy)
                for (int k = 1; k <= N; k++)
                    if (gi < 0 && bus.req_valid[(m_last + k) % N]) gi = (m_last + k) % N;
            e_ready = '0;
            if (gi >= 0) e_ready[gi] = 1'b1;
            e_valid = m_busy && m_wait == 0;
            chk("req_ready", bus.req_ready, e_ready);
            chk("rsp_valid", bus.rsp_valid, e_valid);
            chk("rsp_flags", {bus.rsp_less, bus.rsp_eq, bus.rsp_greater}, e_valid ? m_flags : 3'b000);
            chk("rsp_id", bus.rsp_id, e_valid ? m_id : 0);
            chk("busy", bus.busy, m_busy);
            if (e_valid && bus.rsp_ready) m_busy = 1'b0;
            else if (m_busy && m_wait > 0) m_wait--;
            if (gi >= 0) begin
                ma      = bus.req_a[gi*W +: W];
                mb      = bus.req_b[gi*W +: W];
                m_flags = flags_of(ma, mb);
                m_wait  = lat_of(ma, mb) - 1;
                m_busy  = 1'b1;
                m_id    = gi;
                m_last  = gi;
            end
        end
    end

    // One directed operation on requester i with optional backpressure cycles
    task automatic op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int lat, input logic [2:0] f, input int bp);
        int n;
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_valid[i] = 1'b1;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        @(negedge clk);
        chk("op_grant", bus.req_ready, 1 << i);
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 1;
        while (!bus.rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("op_latency", n, lat);
        chk("op_flags", {bus.rsp_less, bus.rsp_eq, bus.rsp_greater}, f);
        chk("op_id", bus.rsp_id, i);
        for (int c = 0; c < bp; c++) begin
            bus.req_valid = '1;
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_flags", {bus.rsp_less, bus.rsp_eq, bus.rsp_greater}, f);
            chk("bp_req_ready", bus.req_ready, 0);
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("op_accepted", bus.rsp_valid, 0);
    endtask

    initial begin
        int n;
        int prev;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        rst = 1'b0;

        // Directed operations with literal expectations
        op(0, 8'h5A, 8'h5A, 9, 3'b010, 0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        op(1, 8'h80, 8'h7F, 2, 3'b001, 0);
        op(0, 8'h00, 8'hFF, 2, 3'b100, 0);
`else
        op(1, 8'h80, 8'h7F, 9, 3'b001, 0);
        op(0, 8'h00, 8'hFF, 9, 3'b100, 0);
`endif
        op(1, 8'hFE, 8'hFF, 9, 3'b100, 5);

        // Both requesters continuously valid: grants alternate every WIDTH+2 cycles
        bus.req_a = {8'h11, 8'h11};
        bus.req_b = {8'h11, 8'h11};
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            @(negedge clk);
            while (bus.req_ready == '0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("alt_grant", bus.req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            if (g > 0) chk("alt_spacing", cyc - prev, W + 2);
            prev = cyc;
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (12) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;

        // Reset during SHIFT when the counter is at 4
        @(posedge clk); #1;
        bus.req_a[0 +: W] = 8'h33;
        bus.req_b[0 +: W] = 8'h33;
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #2;
        bus.req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
        chk("midrst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_less, bus.rsp_eq, bus.rsp_greater}, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("post_rst_latency", n, W);
        chk("post_rst_id", bus.rsp_id, 0);
        chk("post_rst_eq", bus.rsp_eq, 1);
        repeat (2) @(posedge clk);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            #1;
            bus.req_valid = N'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                bus.req_a[i*W +: W] = W'($urandom);
                bus.req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? bus.req_a[i*W +: W] : W'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
        end
        #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_idle", bus.busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
